iter_div_unit: RTL and testbench

- Parametrised, standalone iterative radix-2 integer divider for the RV32M/RV64M DIV/DIVU/REM/REMU group.
- Replaces divide sequencing embedded in the register file, and owns its own subtractor.
- Sits beside the execute stage and talks to the pipeline over valid/ready request and response channels.
- Carries a destination tag so writeback can be scheduled, and supports a pipeline kill.

---
 rtl/iter_div_unit.sv | 141 ++++++++++++++
 tb/tb_iter_div_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU with valid/ready request/response and kill.
// Optional macro ITER_DIV_EARLY_OUT_EN: short-circuit |a| < |b| and a == 0 in PREP.
module iter_div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  a_raw, abs_a, abs_b, rem, quot, res;
    logic             q_neg, r_neg, special;

    logic             accept, a_neg_in, b_neg_in;
    logic             div_by_zero, overflow, early;
    logic [XLEN:0]    trial;

    assign req_ready  = (state == IDLE) & ~kill;
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);

    assign a_neg_in = ~req_op[0] & req_a[XLEN-1];
    assign b_neg_in = ~req_op[0] & req_b[XLEN-1];

    // r_neg means a is negative and ~q_neg then means b is negative too, so
    // |a|==MIN and |b|==1 identify exactly MIN / -1.
    assign div_by_zero = (abs_b == '0);
    assign overflow    = r_neg & ~q_neg & (abs_a == MIN_NEG) & (abs_b == ONE);
`ifdef ITER_DIV_EARLY_OUT_EN
    assign early = (abs_a < abs_b) | (abs_a == '0);
`else
    assign early = 1'b0;
`endif

    assign trial = {rem, quot[XLEN-1]} - {1'b0, abs_b};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Short-circuited results still pass through FIX so that their response
    // lands two edges after acceptance, matching the normal path's FIX stage.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = PREP;
            PREP: state_nxt = (div_by_zero | overflow | early) ? FIX : ITER;
            ITER: if (count == CNT_MAX) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            op        <= '0;
            tag       <= '0;
            a_raw     <= '0;
            abs_a     <= '0;
            abs_b     <= '0;
            rem       <= '0;
            quot      <= '0;
            res       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            special   <= 1'b0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    op      <= req_op;
                    tag     <= req_tag;
                    a_raw   <= req_a;
                    abs_a   <= a_neg_in ? -req_a : req_a;
                    abs_b   <= b_neg_in ? -req_b : req_b;
                    q_neg   <= a_neg_in ^ b_neg_in;
                    r_neg   <= a_neg_in;
                    special <= 1'b0;
                end
                PREP: begin
                    count <= '0;
                    rem   <= '0;
                    quot  <= abs_a;
                    if (div_by_zero) begin
                        special <= 1'b1;
                        res     <= op[1] ? a_raw : '1;
                    end else if (overflow) begin
                        special <= 1'b1;
                        res     <= op[1] ? '0 : a_raw;
                    end else if (early) begin
                        special <= 1'b1;
                        res     <= op[1] ? a_raw : '0;
                    end
                end
                ITER: begin
                    count <= (count == CNT_MAX) ? '0 : count + CNT_W'(1);
                    quot  <= {quot[XLEN-2:0], ~trial[XLEN]};
                    if (!trial[XLEN]) rem <= trial[XLEN-1:0];
                    else              rem <= {rem[XLEN-2:0], quot[XLEN-1]};
                end
                FIX: begin
                    resp_tag <= tag;
                    if (special)    resp_data <= res;
                    else if (op[1]) resp_data <= r_neg ? -rem : rem;
                    else            resp_data <= q_neg ? -quot : quot;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit (XLEN=32): directed vectors, random ops vs. arithmetic model,
// back-pressure, kill and mid-operation reset.
module tb_iter_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_tag = '0;
    logic        kill = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    iter_div_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension division semantics in plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!op[0] && a[31]) ? 32'd0 - a : a;
        mb = (!op[0] && b[31]) ? 32'd0 - b : b;
        if (b == 32'd0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef ITER_DIV_EARLY_OUT_EN
        if (ma < mb || a == 32'd0) return 2;
`endif
        return 34;
    endfunction

    // Drives one request, returns the first response and edges from acceptance to resp_valid.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] data, output logic [4:0] rtag,
                         output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 999;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        data = resp_data;
        rtag = resp_tag;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", resp_data); end
        checks++; if (resp_tag !== 5'd0) begin errors++; $display("FAIL reset_tag got %h want 0", resp_tag); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops[8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
        logic [31:0] as[8]  = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd2, 32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp[8] = '{32'hFFFF_FFF2, 32'd2, 32'h7FFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          lats[8];
        logic [31:0] d;
        logic [4:0]  t;
        int          l;
`ifdef ITER_DIV_EARLY_OUT_EN
        lats = '{34, 34, 34, 2, 2, 2, 2, 2};
`else
        lats = '{34, 34, 34, 34, 2, 2, 2, 2};
`endif
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 3), d, t, l);
            checks++; if (d !== exp[i]) begin errors++; $display("FAIL dir%0d_data got %h want %h", i, d, exp[i]); end
            checks++; if (t !== 5'(i + 3)) begin errors++; $display("FAIL dir%0d_tag got %h want %h", i, t, 5'(i + 3)); end
            checks++; if (l != lats[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, l, lats[i]); end
            consume();
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, d;
        logic [4:0]  tg, t;
        int          l;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            tg = 5'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'd0;
                2: a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            issue(op, a, b, tg, d, t, l);
            checks++; if (d !== ref_result(op, a, b)) begin errors++; $display("FAIL rnd%0d_data op=%0d a=%h b=%h got %h want %h", i, op, a, b, d, ref_result(op, a, b)); end
            checks++; if (t !== tg) begin errors++; $display("FAIL rnd%0d_tag got %h want %h", i, t, tg); end
            checks++; if (l != ref_latency(op, a, b)) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, l, ref_latency(op, a, b)); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [4:0]  t;
        int          l;
        issue(2'b00, 32'd1000, 32'd7, 5'h1A, d, t, l);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_valid got %b want 1", c, resp_valid); end
            checks++; if (resp_data !== 32'd142) begin errors++; $display("FAIL bp%0d_data got %h want %h", c, resp_data, 32'd142); end
            checks++; if (resp_tag !== 5'h1A) begin errors++; $display("FAIL bp%0d_tag got %h want 1a", c, resp_tag); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_ready got %b want 0", c, req_ready); end
        end
        consume();
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release busy=%b valid=%b want 0 0", busy, resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", req_ready); end
        issue(2'b01, 32'd50, 32'd6, 5'h05, d, t, l);
        checks++; if (d !== 32'd8 || t !== 5'h05 || l != 34) begin errors++; $display("FAIL bp_next got %h/%h/%0d want 8/05/34", d, t, l); end
        consume();
    endtask

    task automatic test_kill();
        logic [31:0] d;
        logic [4:0]  t;
        int          l;
        bit          seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_a = 32'hFFFF_FFFF; req_b = 32'd3; req_tag = 5'h11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 kill = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL kill_ready got %b want 0", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kill_busy_before got %b want 1", busy); end
        @(posedge clk);
        #1 kill = 1'b0;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL kill_idle busy=%b valid=%b want 0 0", busy, resp_valid); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (resp_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL kill_no_resp got response want none"); end
        issue(2'b01, 32'd9, 32'd3, 5'h0C, d, t, l);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL kill_next_data got %h want 3", d); end
        checks++; if (t !== 5'h0C) begin errors++; $display("FAIL kill_next_tag got %h want 0c", t); end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [4:0]  t;
        int          l;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'd12345; req_b = 32'd17; req_tag = 5'h07;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid busy=%b valid=%b want 0 0", busy, resp_valid); end
        checks++; if (resp_data !== 32'd0 || resp_tag !== 5'd0) begin errors++; $display("FAIL rstmid_regs data=%h tag=%h want 0 0", resp_data, resp_tag); end
        reset = 1'b0;
        issue(2'b10, 32'hFFFF_FFEF, 32'd5, 5'h13, d, t, l);
        checks++; if (d !== 32'hFFFF_FFFE || t !== 5'h13 || l != 34) begin errors++; $display("FAIL rstmid_next got %h/%h/%0d want fffffffe/13/34", d, t, l); end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_kill();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
